fdc_sd_arbiter: RTL and testbench
=================================

// Module: fdc_sd_arbiter
// PURPOSE
//  Merges the four per-drive SD block channels of the floppy controller onto one host SD block channel.
//  Grants one drive at a time and latches that drive's LBA and operation.
//  Routes host ack and buffer traffic back to the granted drive only.
//  Sits between the four wd1793 instances (upstream) and the single host SD port (downstream).
// PARAMETERS
//  NDRIVES      4        number of drive channels (2..4)
//  ACK_TIMEOUT  24'hFFFFFF  cycles in ISSUE without sd_ack before abort; 0 disables the timeout
// PORTS
//  CLK           in   1        system clock; all state updates on its rising edge
//  RESET         in   1        synchronous, active-high reset
//  drv_lba       in   32 x N   per-drive block address (sd_lba[i] of drive i)
//  drv_rd        in   N        per-drive read request (level)
//  drv_wr        in   N        per-drive write request (level)
//  drv_ack       out  N        per-drive ack; only the granted bit may be 1
//  drv_buff_din  in   8 x N    per-drive buffer read data (drive -> SD)
//  drv_buff_wr   out  N        per-drive gated buffer write strobe
//  sd_lba        out  32       latched LBA of the granted drive
//  sd_rd         out  1        host read request
//  sd_wr         out  1        host write request
//  sd_ack        in   1        host ack, high for the whole transfer
//  sd_buff_wr    in   1        host buffer write strobe (SD -> drive)
//  sd_buff_din   out  8        drv_buff_din of the granted drive, else 8'h00
//  grant_idx     out  2        index of the current or last granted drive
//  busy          out  1        1 in any state other than IDLE
//  timeout_err   out  1        sticky; set on abort, cleared only by RESET
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, grant_idx=0; sd_rd, sd_wr, busy and timeout_err = 0; sd_lba = 0.
//  Reset: all drv_ack and drv_buff_wr = 0. Reset mid-transfer takes effect on the next edge; the request is dropped.
//  FSM IDLE -> ISSUE -> XFER -> IDLE. ISSUE -> IDLE on abort.
//  IDLE:
//   - req[i] = drv_rd[i] | drv_wr[i].
//   - Pick the first i with req[i] set, searching round-robin from rr_ptr.
//   - Latch grant_idx=i, sd_lba=drv_lba[i], op = wr ? WRITE : READ. If rd and wr are both set, WRITE wins.
//   - Go to ISSUE. sd_rd/sd_wr are registered: request seen at cycle n, asserted at cycle n+1.
//  ISSUE:
//   - Hold sd_rd or sd_wr high and count cycles.
//   - sd_ack=1: go to XFER, drop sd_rd/sd_wr, set drv_ack[grant]=1.
//   - Granted drive drops both rd and wr before ack: clean cancel. Go to IDLE with no ack and no error.
//   - Count reaches ACK_TIMEOUT (nonzero): drop the request, set timeout_err, go to IDLE.
//  XFER:
//   - drv_ack[grant] = sd_ack, registered (one cycle late).
//   - drv_buff_wr[grant] = sd_buff_wr, combinational (same cycle).
//   - sd_buff_din = drv_buff_din[grant], combinational (same cycle).
//   - sd_ack=0: drv_ack=0, rr_ptr=grant+1 (mod NDRIVES), go to IDLE.
//  Requests from non-granted drives are held pending and never lost, because they are levels.
//  sd_ack or sd_buff_wr while IDLE is stale: ignored and not routed to any drive.
//  Minimum gap between transfers: 1 IDLE cycle. A back-to-back request from the same drive yields to other pending drives.
//  Selected drive i >= NDRIVES never occurs; tie unused request bits to 0.
// STRUCTURE
//  Shared package fdc_pkg:
//   - typedef enum {IDLE, ISSUE, XFER} arb_state_t
//   - typedef enum {OP_READ, OP_WRITE} sd_op_t
//   - localparam FDC_NDRIVES = 4
//  Sub-module rr_pick: combinational round-robin priority encoder (req vector, rr_ptr -> idx, valid).
//  All remaining logic stays in this module.
// TESTING
//  1. Drive 0 rd with lba=0x12 -> sd_rd=1 next cycle, sd_lba=0x12; ack 600 cycles -> drv_ack[0] follows; 512 buff_wr pulses reach drv_buff_wr[0] only.
//  2. Drives 1 and 3 both request at rr_ptr=0 -> drive 1 served first, then drive 3; rr_ptr ends at 0.
//  3. Drive 2 raises rd and wr together -> sd_wr=1, sd_rd=0; sd_buff_din tracks drv_buff_din[2] byte-for-byte.
//  4. ACK_TIMEOUT=16, drive 0 requests, no ack -> sd_rd drops at cycle 16, timeout_err=1, busy=0.
//  5. RESET asserted mid-XFER -> next cycle all outputs 0, state IDLE; a pending request is re-granted after RESET drops.
//  6. sd_ack pulse while IDLE -> no drv_ack bit and no drv_buff_wr bit changes.

Source files
------------

// File: rtl/fdc_pkg.sv
// Shared types and constants for the floppy-controller SD block arbiter.
// Index width covers up to four drives.
package fdc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } sd_op_t;

    localparam int FDC_NDRIVES = 4;
    localparam int IDX_W       = 2;
    localparam int LBA_W       = 32;

endpackage

// File: rtl/fdc_sd_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, wrapping modulo N.
module rr_pick
    import fdc_pkg::*;
#(
    parameter int N = FDC_NDRIVES
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Rotate so that bit 0 of rot is the request at ptr; the lowest set bit wins.
    always_comb begin
        dbl = {req, req};
        rot = N'(dbl >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx   = sum[IDX_W-1:0];
        valid = |req;
    end

endmodule

// File: rtl/fdc_sd_arbiter.sv
// Merges the per-drive SD block channels onto one host SD channel. One drive is
// granted at a time; host ack and buffer strobes are routed back to it only.
module fdc_sd_arbiter
    import fdc_pkg::*;
#(
    parameter int          NDRIVES     = FDC_NDRIVES,
    parameter logic [23:0] ACK_TIMEOUT = 24'hFFFFFF
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NDRIVES-1:0][LBA_W-1:0] drv_lba,
    input  logic [NDRIVES-1:0]            drv_rd,
    input  logic [NDRIVES-1:0]            drv_wr,
    output logic [NDRIVES-1:0]            drv_ack,
    input  logic [NDRIVES-1:0][7:0]       drv_buff_din,
    output logic [NDRIVES-1:0]            drv_buff_wr,
    output logic [LBA_W-1:0]              sd_lba,
    output logic                          sd_rd,
    output logic                          sd_wr,
    input  logic                          sd_ack,
    input  logic                          sd_buff_wr,
    output logic [7:0]                    sd_buff_din,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy,
    output logic                          timeout_err
);

    arb_state_t         state, state_nxt;
    sd_op_t             op, op_nxt;
    logic [NDRIVES-1:0] req;
    logic [NDRIVES-1:0] ack_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt;
    logic [IDX_W-1:0]   grant_nxt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [LBA_W-1:0]   lba_nxt;
    logic [23:0]        wait_cnt, wait_nxt;
    logic               err_nxt;

    assign req = drv_rd | drv_wr;

    rr_pick #(
        .N(NDRIVES)
    ) u_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .idx  (pick_idx),
        .valid(pick_valid)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            op          <= OP_READ;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            sd_lba      <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            drv_ack     <= '0;
        end else begin
            state       <= state_nxt;
            op          <= op_nxt;
            rr_ptr      <= rr_nxt;
            grant_idx   <= grant_nxt;
            sd_lba      <= lba_nxt;
            wait_cnt    <= wait_nxt;
            timeout_err <= err_nxt;
            drv_ack     <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        rr_nxt    = rr_ptr;
        grant_nxt = grant_idx;
        lba_nxt   = sd_lba;
        wait_nxt  = wait_cnt;
        err_nxt   = timeout_err;
        ack_nxt   = drv_ack;
        unique case (state)
            IDLE: begin
                // Stale host ack/strobes are ignored here; only drive requests matter.
                ack_nxt = '0;
                if (pick_valid) begin
                    state_nxt = ISSUE;
                    grant_nxt = pick_idx;
                    lba_nxt   = drv_lba[pick_idx];
                    op_nxt    = drv_wr[pick_idx] ? OP_WRITE : OP_READ;
                    wait_nxt  = '0;
                end
            end
            ISSUE: begin
                // An ack that arrives together with a cancel or the last timeout cycle wins.
                if (sd_ack) begin
                    state_nxt          = XFER;
                    ack_nxt            = '0;
                    ack_nxt[grant_idx] = 1'b1;
                end else if (!req[grant_idx]) begin
                    state_nxt = IDLE;
                end else if ((ACK_TIMEOUT != '0) && (wait_cnt == ACK_TIMEOUT - 24'd1)) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 24'd1;
                end
            end
            XFER: begin
                ack_nxt = '0;
                if (sd_ack) begin
                    ack_nxt[grant_idx] = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    rr_nxt    = (int'(grant_idx) == NDRIVES - 1) ? '0 : grant_idx + IDX_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy  = (state != IDLE);
    assign sd_rd = (state == ISSUE) && (op == OP_READ);
    assign sd_wr = (state == ISSUE) && (op == OP_WRITE);

    // Buffer traffic is a same-cycle pass-through to the granted drive only.
    always_comb begin
        drv_buff_wr = '0;
        sd_buff_din = 8'h00;
        if (state == XFER) begin
            drv_buff_wr[grant_idx] = sd_buff_wr;
            sd_buff_din            = drv_buff_din[grant_idx];
        end
    end

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Bench for fdc_sd_arbiter: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_fdc_sd_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic                CLK = 1'b0;
    logic                RESET;
    logic [N-1:0][31:0]  drv_lba;
    logic [N-1:0]        drv_rd;
    logic [N-1:0]        drv_wr;
    logic [N-1:0]        drv_ack;
    logic [N-1:0][7:0]   drv_buff_din;
    logic [N-1:0]        drv_buff_wr;
    logic [31:0]         sd_lba;
    logic                sd_rd;
    logic                sd_wr;
    logic                sd_ack;
    logic                sd_buff_wr;
    logic [7:0]          sd_buff_din;
    logic [1:0]          grant_idx;
    logic                busy;
    logic                timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fdc_sd_arbiter #(
        .NDRIVES    (N),
        .ACK_TIMEOUT(24'(TO))
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .drv_lba     (drv_lba),
        .drv_rd      (drv_rd),
        .drv_wr      (drv_wr),
        .drv_ack     (drv_ack),
        .drv_buff_din(drv_buff_din),
        .drv_buff_wr (drv_buff_wr),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = no transfer, 1 = request outstanding, 2 = host ack running.
    int          m_phase = 0;
    int          m_grant = 0;
    int          m_ptr   = 0;
    int          m_waited = 0;
    logic [31:0] m_lba   = '0;
    bit          m_write = 0;
    bit          m_err   = 0;
    bit          m_ack   = 0;

    task automatic model_step();
        int g;
        bit found;
        if (RESET) begin
            m_phase = 0; m_grant = 0; m_ptr = 0; m_waited = 0;
            m_lba = '0; m_write = 0; m_err = 0; m_ack = 0;
        end else if (m_phase == 0) begin
            m_ack = 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                g = (m_ptr + k) % N;
                if (!found && (drv_rd[g] || drv_wr[g])) begin
                    found = 1; m_grant = g; m_lba = drv_lba[g];
                    m_write = drv_wr[g]; m_waited = 0; m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (sd_ack) begin
                m_phase = 2; m_ack = 1;
            end else if (!(drv_rd[m_grant] || drv_wr[m_grant])) begin
                m_phase = 0;
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    m_phase = 0; m_err = 1;
                end
            end
        end else begin
            m_ack = sd_ack;
            if (!sd_ack) begin
                m_phase = 0;
                m_ptr = (m_grant + 1) % N;
            end
        end
    endtask

    task automatic compare_outputs();
        check("busy",        32'(busy),        32'(m_phase != 0));
        check("sd_rd",       32'(sd_rd),       32'(m_phase == 1 && !m_write));
        check("sd_wr",       32'(sd_wr),       32'(m_phase == 1 && m_write));
        check("sd_lba",      sd_lba,           m_lba);
        check("grant_idx",   32'(grant_idx),   32'(m_grant));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        check("drv_ack",     32'(drv_ack),     m_ack ? (32'd1 << m_grant) : 32'd0);
        check("drv_buff_wr", 32'(drv_buff_wr), (m_phase == 2 && sd_buff_wr) ? (32'd1 << m_grant) : 32'd0);
        check("sd_buff_din", 32'(sd_buff_din), (m_phase == 2) ? 32'(drv_buff_din[m_grant]) : 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_step();
            @(negedge CLK);
            #2;
            compare_outputs();
        end
    end

    // Host and drive behaviour, all driven from the main thread.
    int h_state = 0, h_cnt = 0, h_pos = 0, h_len = 0;
    bit host_en = 0, host_window = 0, rand_en = 0, force_stale = 0;
    int host_max_dly = 0, host_len_min = 1, host_len_max = 1;

    task automatic host_tick();
        if (h_state == 0 && host_en && (sd_rd || sd_wr)) begin
            h_cnt = $urandom_range(host_max_dly, 0);
            h_state = 1;
        end
        if (h_state == 1) begin
            if (!(sd_rd || sd_wr)) h_state = 0;
            else if (h_cnt == 0) begin
                h_state = 2; h_pos = 0;
                h_len = $urandom_range(host_len_max, host_len_min);
            end else h_cnt--;
        end
        if (h_state == 2) begin
            if (h_pos < h_len) begin
                sd_ack = 1'b1;
                sd_buff_wr = host_window ? (h_pos >= 40 && h_pos < 552) : 1'($urandom_range(1, 0));
                h_pos++;
            end else begin
                sd_ack = 1'b0; sd_buff_wr = 1'b0; h_state = 0;
            end
        end else begin
            sd_ack = 1'b0; sd_buff_wr = 1'b0;
        end
    endtask

    task automatic drive_tick();
        for (int i = 0; i < N; i++) begin
            drv_buff_din[i] = 8'($urandom);
            if (drv_ack[i]) begin
                drv_rd[i] = 1'b0; drv_wr[i] = 1'b0;
            end else if (rand_en) begin
                if (!(drv_rd[i] || drv_wr[i])) begin
                    if ($urandom_range(7, 0) == 0) begin
                        drv_lba[i] = $urandom;
                        case ($urandom_range(2, 0))
                            0:       drv_rd[i] = 1'b1;
                            1:       drv_wr[i] = 1'b1;
                            default: begin drv_rd[i] = 1'b1; drv_wr[i] = 1'b1; end
                        endcase
                    end
                end else if ($urandom_range(63, 0) == 0) begin
                    drv_rd[i] = 1'b0; drv_wr[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        host_tick();
        if (force_stale) begin
            sd_ack = 1'b1; sd_buff_wr = 1'b1;
        end
        drive_tick();
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic wait_quiet(input int bound);
        int c;
        c = 0;
        while (c < bound && (busy || drv_rd != '0 || drv_wr != '0)) begin
            tick();
            c++;
        end
        tick();
        check("wait_quiet", 32'(busy), 32'd0);
    endtask

    int  pulses, stray, ack_cycles, hi, nseen, order0, order1;
    bit  prev_busy, stop;

    initial begin
        RESET = 1'b1;
        drv_rd = '0; drv_wr = '0; drv_lba = '0; drv_buff_din = '0;
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        repeat (3) tick();
        check("reset_busy",  32'(busy),        32'd0);
        check("reset_lba",   sd_lba,           32'd0);
        check("reset_ack",   32'(drv_ack),     32'd0);
        check("reset_grant", 32'(grant_idx),   32'd0);
        check("reset_err",   32'(timeout_err), 32'd0);
        RESET = 1'b0;
        tick();

        // Long read from drive 0 with 512 buffer strobes.
        host_en = 1; host_max_dly = 0; host_len_min = 600; host_len_max = 600; host_window = 1;
        drv_lba[0] = 32'h12; drv_rd[0] = 1'b1;
        tick();
        check("t1_sd_rd", 32'(sd_rd), 32'd1);
        check("t1_lba",   sd_lba,     32'h12);
        pulses = 0; stray = 0; ack_cycles = 0; stop = 0;
        for (int c = 0; c < 900 && !stop; c++) begin
            tick();
            if (drv_buff_wr == 4'b0001) pulses++;
            else if (drv_buff_wr != 4'b0000) stray++;
            if (drv_ack == 4'b0001) ack_cycles++;
            else if (drv_ack != 4'b0000) stray++;
            if (ack_cycles > 0 && !busy) stop = 1;
        end
        check("t1_pulses",     32'(pulses),     32'd512);
        check("t1_stray",      32'(stray),      32'd0);
        check("t1_ack_cycles", 32'(ack_cycles), 32'd600);
        host_window = 0;
        wait_quiet(50);

        // Drives 1 and 3 together from rr_ptr=0.
        do_reset();
        host_max_dly = 2; host_len_min = 3; host_len_max = 6;
        drv_lba[1] = 32'h111; drv_lba[3] = 32'h333;
        drv_rd[1] = 1'b1; drv_rd[3] = 1'b1;
        nseen = 0; prev_busy = 0; order0 = -1; order1 = -1; stop = 0;
        for (int c = 0; c < 200 && !stop; c++) begin
            tick();
            if (busy && !prev_busy) begin
                if (nseen == 0) order0 = int'(grant_idx);
                else if (nseen == 1) order1 = int'(grant_idx);
                nseen++;
            end
            prev_busy = busy;
            if (nseen >= 2 && !busy) stop = 1;
        end
        check("t2_first",  32'(order0), 32'd1);
        check("t2_second", 32'(order1), 32'd3);
        drv_rd[0] = 1'b1; drv_rd[3] = 1'b1;
        tick();
        check("t2_ptr_wrapped", 32'(grant_idx), 32'd0);
        wait_quiet(200);

        // Drive 2 with rd and wr together: write wins.
        host_max_dly = 1; host_len_min = 8; host_len_max = 8;
        drv_lba[2] = 32'hABCD; drv_rd[2] = 1'b1; drv_wr[2] = 1'b1;
        tick();
        check("t3_sd_wr", 32'(sd_wr), 32'd1);
        check("t3_sd_rd", 32'(sd_rd), 32'd0);
        stop = 0;
        for (int c = 0; c < 20 && !stop; c++) begin
            tick();
            if (drv_ack[2]) stop = 1;
        end
        drv_buff_din[2] = 8'hA5;
        #1;
        check("t3_din", 32'(sd_buff_din), 32'hA5);
        wait_quiet(50);

        // No host ack: abort after TO request cycles.
        host_en = 0;
        drv_lba[0] = 32'h40; drv_rd[0] = 1'b1;
        hi = 0; stop = 0;
        for (int c = 0; c < 100 && !stop; c++) begin
            tick();
            if (sd_rd) hi++;
            else stop = 1;
        end
        check("t4_rd_cycles", 32'(hi),          32'(TO));
        check("t4_err",       32'(timeout_err), 32'd1);
        check("t4_busy",      32'(busy),        32'd0);
        drv_rd[0] = 1'b0;
        tick(); tick();

        // Reset during XFER with drive 3 pending.
        do_reset();
        host_en = 1; host_max_dly = 0; host_len_min = 50; host_len_max = 50;
        drv_lba[1] = 32'h77; drv_rd[1] = 1'b1;
        stop = 0;
        for (int c = 0; c < 30 && !stop; c++) begin
            tick();
            if (drv_ack[1]) stop = 1;
        end
        drv_lba[3] = 32'h99; drv_rd[3] = 1'b1;
        tick(); tick();
        check("t5_in_xfer", 32'(drv_ack), 32'b0010);
        RESET = 1'b1; host_en = 0; h_state = 0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        tick();
        check("t5_busy",  32'(busy),      32'd0);
        check("t5_ack",   32'(drv_ack),   32'd0);
        check("t5_lba",   sd_lba,         32'd0);
        check("t5_grant", 32'(grant_idx), 32'd0);
        check("t5_rdwr",  32'({sd_rd, sd_wr}), 32'd0);
        RESET = 1'b0; host_en = 1; host_len_min = 4; host_len_max = 4;
        stop = 0;
        for (int c = 0; c < 10 && !stop; c++) begin
            tick();
            if (busy) stop = 1;
        end
        check("t5_regrant",     32'(grant_idx), 32'd3);
        check("t5_regrant_lba", sd_lba,         32'h99);
        wait_quiet(50);

        // Stale ack and strobe while idle.
        host_en = 0; force_stale = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t6_drv_ack", 32'(drv_ack),     32'd0);
            check("t6_buff_wr", 32'(drv_buff_wr), 32'd0);
        end
        force_stale = 0;
        tick(); tick();
        check("t6_after", 32'(drv_ack), 32'd0);

        // Randomized traffic, including timeouts and cancels.
        host_en = 1; rand_en = 1; host_max_dly = 20; host_len_min = 1; host_len_max = 12;
        repeat (4000) tick();
        rand_en = 0; host_max_dly = 2;
        wait_quiet(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
